// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: one recoding step per clock.
// The accumulator is N+1 bits wide, so the most negative multiplicand stays exact.
module booth_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N:0]     a_q, a_d;
  logic [N:0]     m_q, m_d;
  logic [N-1:0]   q_q, q_d;
  logic           qm1_q, qm1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d;
  logic           done_q, done_d;

  logic [N:0]     sum_s;
  logic [N:0]     sh_a_s;
  logic [N-1:0]   sh_q_s;

  // Booth recoding of {Q0, Q(-1)} selects add, subtract or pass-through.
  always_comb begin
    sum_s = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   sum_s = a_q + m_q;
      2'b10:   sum_s = a_q - m_q;
      default: sum_s = a_q;
    endcase
  end

  // Arithmetic shift right of {A,Q} by one, sign taken from the new A.
  always_comb begin
    sh_a_s = {sum_s[N], sum_s[N:1]};
    sh_q_s = {sum_s[0], q_q[N-1:1]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = '0;
          m_d     = {multiplicand[N-1], multiplicand};
          q_d     = multiplier;
          qm1_d   = 1'b0;
          cnt_d   = CW'(N);
          done_d  = 1'b0;
          state_d = RUN;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        a_d   = sh_a_s;
        q_d   = sh_q_s;
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        // Last step: the product is the low 2N bits of the shifted {A,Q}.
        if (cnt_q == CW'(1)) begin
          product_d = {sh_a_s[N-1:0], sh_q_s};
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign done    = done_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier at N=4 and N=8: an arithmetic
// reference model checked every cycle plus directed hand-computed vectors.
module tb_booth_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic              start4 = 1'b0;
  logic signed [3:0] mc4 = 4'sd0;
  logic signed [3:0] mp4 = 4'sd0;
  logic [7:0]        product4;
  logic              done4;

  logic              start8 = 1'b0;
  logic signed [7:0] mc8 = 8'sd0;
  logic signed [7:0] mp8 = 8'sd0;
  logic [15:0]       product8;
  logic              done8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  booth_multiplier #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .multiplicand(mc4), .multiplier(mp4),
    .product(product4), .done(done4)
  );

  booth_multiplier #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .multiplicand(mc8), .multiplier(mp8),
    .product(product8), .done(done8)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted start yields M*Q and done exactly N edges later.
  logic              busy4, exp_d4;
  int                cnt4;
  logic signed [3:0] ma4, mb4;
  logic [7:0]        exp_p4;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy4 <= 1'b0; cnt4 <= 0; exp_p4 <= 8'h00; exp_d4 <= 1'b0;
      ma4 <= 4'sd0; mb4 <= 4'sd0;
    end else if (busy4) begin
      if (cnt4 == 1) begin
        exp_p4 <= ma4 * mb4;
        exp_d4 <= 1'b1;
        busy4  <= 1'b0;
      end
      cnt4 <= cnt4 - 1;
    end else if (start4) begin
      ma4 <= mc4; mb4 <= mp4; busy4 <= 1'b1; cnt4 <= 4; exp_d4 <= 1'b0;
    end
  end

  logic              busy8, exp_d8;
  int                cnt8;
  logic signed [7:0] ma8, mb8;
  logic [15:0]       exp_p8;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy8 <= 1'b0; cnt8 <= 0; exp_p8 <= 16'h0000; exp_d8 <= 1'b0;
      ma8 <= 8'sd0; mb8 <= 8'sd0;
    end else if (busy8) begin
      if (cnt8 == 1) begin
        exp_p8 <= ma8 * mb8;
        exp_d8 <= 1'b1;
        busy8  <= 1'b0;
      end
      cnt8 <= cnt8 - 1;
    end else if (start8) begin
      ma8 <= mc8; mb8 <= mp8; busy8 <= 1'b1; cnt8 <= 8; exp_d8 <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("cyc4_product", {8'h00, product4}, {8'h00, exp_p4});
    chk("cyc4_done", {15'h0000, done4}, {15'h0000, exp_d4});
    chk("cyc8_product", product8, exp_p8);
    chk("cyc8_done", {15'h0000, done8}, {15'h0000, exp_d8});
  end

  task automatic mul4(input logic signed [3:0] a, input logic signed [3:0] b,
                      input logic signed [7:0] e, input string nm);
    @(negedge clk);
    mc4 = a; mp4 = b; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk({nm, "_accept_done"}, {15'h0000, done4}, 16'h0000);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk({nm, "_early_done"}, {15'h0000, done4}, 16'h0000);
    end
    @(negedge clk);
    chk({nm, "_done"}, {15'h0000, done4}, 16'h0001);
    chk({nm, "_product"}, {8'h00, product4}, {8'h00, e});
  endtask

  task automatic mul8(input logic signed [7:0] a, input logic signed [7:0] b,
                      input logic signed [15:0] e, input string nm);
    @(negedge clk);
    mc8 = a; mp8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk({nm, "_accept_done"}, {15'h0000, done8}, 16'h0000);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk({nm, "_early_done"}, {15'h0000, done8}, 16'h0000);
    end
    @(negedge clk);
    chk({nm, "_done"}, {15'h0000, done8}, 16'h0001);
    chk({nm, "_product"}, product8, e);
  endtask

  initial begin
    int   rises;
    logic prev;
    int   ai, bi;

    #1 rst = 1'b1;
    #2;
    chk("reset_product4", {8'h00, product4}, 16'h0000);
    chk("reset_done4", {15'h0000, done4}, 16'h0000);
    chk("reset_product8", product8, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-computed results.
    mul4(-4'sd3, 4'sd5, 8'shF1, "m3x5");
    mul4(-4'sd4, -4'sd2, 8'sd8, "m4xm2");
    mul4(4'sd7, 4'sd3, 8'sd21, "7x3");
    mul4(-4'sd8, -4'sd8, 8'sd64, "m8xm8");
    mul4(-4'sd8, 4'sd7, -8'sd56, "m8x7");
    mul4(4'sd0, -4'sd8, 8'sd0, "0xm8");
    mul4(-4'sd1, -4'sd1, 8'sd1, "m1xm1");

    // start re-pulsed and operands changed while running: ignored.
    @(negedge clk);
    mc4 = 4'sd3; mp4 = -4'sd5; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; mc4 = 4'sd7; mp4 = 4'sd7;
    @(negedge clk);
    @(negedge clk);
    start4 = 1'b0;
    chk("midrun_early_done", {15'h0000, done4}, 16'h0000);
    @(negedge clk);
    chk("midrun_done", {15'h0000, done4}, 16'h0001);
    chk("midrun_product", {8'h00, product4}, 16'h00F1);

    // Reset during RUN aborts the multiply at once.
    @(negedge clk);
    mc4 = 4'sd6; mp4 = 4'sd6; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_product", {8'h00, product4}, 16'h0000);
    chk("abort_done", {15'h0000, done4}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    mul4(4'sd5, 4'sd5, 8'sd25, "5x5_after_reset");

    // start held high: back-to-back multiplies, one done rise per pass.
    @(negedge clk);
    mc4 = 4'sd2; mp4 = -4'sd3; start4 = 1'b1;
    prev = done4;
    rises = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 11) start4 = 1'b0;
      if (done4 && !prev) rises++;
      prev = done4;
    end
    chk("b2b_done_rises", 16'(rises), 16'd3);
    chk("b2b_product", {8'h00, product4}, 16'h00FA);

    // Every N=4 operand pair against the integer product.
    for (int i = -8; i < 8; i++) begin
      for (int j = -8; j < 8; j++) begin
        mul4(4'(i), 4'(j), 8'(i * j), "exh4");
      end
    end

    // N=8 corners then random pairs.
    mul8(-8'sd128, -8'sd128, 16'sd16384, "n8_m128xm128");
    mul8(-8'sd128, 8'sd127, -16'sd16256, "n8_m128x127");
    mul8(8'sd127, 8'sd127, 16'sd16129, "n8_127x127");
    mul8(8'sd0, -8'sd128, 16'sd0, "n8_0xm128");
    for (int k = 0; k < 200; k++) begin
      ai = int'($urandom_range(255, 0)) - 128;
      bi = int'($urandom_range(255, 0)) - 128;
      mul8(8'(ai), 8'(bi), 16'(ai * bi), "rnd8");
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
